// File: rtl/chs_power_driver.sv
// Soft-ramped 16-slot PWM power-stage driver. The applied level moves one unit
// per RAMP_PERIODS PWM periods toward the mode-gated requested power.
module chs_power_driver #(
  parameter int PRESCALE     = 4,
  parameter int RAMP_PERIODS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chs_mode,
  input  logic [3:0] chs_power,
  output logic       pwm_out,
  output logic [3:0] level,
  output logic [1:0] state,
  output logic       at_target
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, HOLD = 2'd2, DOWN = 2'd3} state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] RAMP_MAX = RW'(RAMP_PERIODS - 1);

  logic [PW-1:0] pre_cnt;
  logic [3:0]    pwm_cnt;
  logic [RW-1:0] rcnt;
  logic [3:0]    target;
  logic          tick, period_end, step_en;
  state_t        st_q;

  assign target     = chs_mode ? chs_power : 4'd0;
  assign tick       = (pre_cnt == PRE_MAX);
  assign period_end = tick && (pwm_cnt == 4'd15);
  assign step_en    = period_end && (rcnt == RAMP_MAX);
  assign state      = st_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      pwm_cnt   <= '0;
      rcnt      <= '0;
      level     <= '0;
      pwm_out   <= 1'b0;
      at_target <= 1'b0;
      st_q      <= IDLE;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 4'd1;
      // rcnt is free-running so the step cadence is unaffected by target changes
      if (period_end)
        rcnt <= (rcnt == RAMP_MAX) ? '0 : rcnt + 1'b1;
      // level only moves at a period boundary, so duty never changes mid-period
      if (step_en) begin
        if (level < target)
          level <= level + 4'd1;
        else if (level > target)
          level <= level - 4'd1;
      end
      pwm_out   <= (level > pwm_cnt);
      at_target <= (level == target);
      if (level < target)
        st_q <= UP;
      else if (level > target)
        st_q <= DOWN;
      else if (level == 4'd0)
        st_q <= IDLE;
      else
        st_q <= HOLD;
    end
  end

endmodule

// File: tb/tb_chs_power_driver.sv
// Directed bench for chs_power_driver: default instance plus a PRESCALE=1,
// RAMP_PERIODS=1 instance for the fast-ramp extreme.
module tb_chs_power_driver;

  logic       clk;
  logic       rst, chs_mode;
  logic [3:0] chs_power;
  logic       pwm_out, at_target;
  logic [3:0] level;
  logic [1:0] state;

  logic       rst2, chs_mode2;
  logic [3:0] chs_power2;
  logic       pwm_out2, at_target2;
  logic [3:0] level2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;
  int n_edge = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_UP = 2'd1, S_HOLD = 2'd2, S_DOWN = 2'd3;

  chs_power_driver dut (
    .clk(clk), .rst(rst), .chs_mode(chs_mode), .chs_power(chs_power),
    .pwm_out(pwm_out), .level(level), .state(state), .at_target(at_target)
  );

  chs_power_driver #(.PRESCALE(1), .RAMP_PERIODS(1)) dut_fast (
    .clk(clk), .rst(rst2), .chs_mode(chs_mode2), .chs_power(chs_power2),
    .pwm_out(pwm_out2), .level(level2), .state(state2), .at_target(at_target2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_edge = 0;
  endtask

  // advance one rising edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    n_edge++;
  endtask

  task automatic test_reset();
    rst = 1'b1; chs_mode = 1'b0; chs_power = 4'd9;
    #1;
    checks++;
    if (level !== 4'd0 || state !== S_IDLE || pwm_out !== 1'b0 || at_target !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: level=%0d state=%0d pwm=%0b at=%0b expected 0 0 0 0",
               level, state, pwm_out, at_target);
    end
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      step();
      checks++;
      if (level !== 4'd0 || state !== S_IDLE || pwm_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_edge%0d: level=%0d state=%0d pwm=%0b expected 0 0 0", i, level, state, pwm_out);
      end
      if (i >= 2) begin
        checks++;
        if (at_target !== 1'b1) begin
          errors++;
          $display("FAIL idle_at_target edge%0d: got %0b expected 1", i, at_target);
        end
      end
    end
  endtask

  task automatic test_ramp_up_and_soft_stop();
    int exp_lvl, prev, hi;
    chs_mode = 1'b1; chs_power = 4'd5;
    do_reset();
    exp_lvl = 0; hi = 0;
    while (n_edge < 1000) begin
      prev = exp_lvl;
      step();
      exp_lvl = (n_edge / 128 > 5) ? 5 : n_edge / 128;
      checks++;
      if (level !== 4'(exp_lvl)) begin
        errors++;
        $display("FAIL ramp_level edge%0d: got %0d expected %0d", n_edge, level, exp_lvl);
      end
      checks++;
      if (state !== ((prev < 5) ? S_UP : S_HOLD) || at_target !== (prev == 5)) begin
        errors++;
        $display("FAIL ramp_state edge%0d: state=%0d at=%0b prev_level=%0d", n_edge, state, at_target, prev);
      end
      if (n_edge >= 701 && n_edge <= 764) hi += int'(pwm_out);
    end
    checks++;
    if (hi != 20) begin
      errors++;
      $display("FAIL hold_duty: got %0d high clk of 64 expected 20", hi);
    end
    // soft stop: steps land on edges 1024,1152,...,1536
    chs_mode = 1'b0;
    while (n_edge < 1700) begin
      prev = exp_lvl;
      step();
      exp_lvl = (n_edge < 1024) ? 5 : 5 - ((n_edge - 1024) / 128 + 1);
      if (exp_lvl < 0) exp_lvl = 0;
      checks++;
      if (level !== 4'(exp_lvl)) begin
        errors++;
        $display("FAIL stop_level edge%0d: got %0d expected %0d", n_edge, level, exp_lvl);
      end
      checks++;
      if (state !== ((prev > 0) ? S_DOWN : S_IDLE)) begin
        errors++;
        $display("FAIL stop_state edge%0d: got %0d expected %0d", n_edge, state, (prev > 0) ? S_DOWN : S_IDLE);
      end
      if (n_edge >= 1537) begin
        checks++;
        if (pwm_out !== 1'b0) begin
          errors++;
          $display("FAIL stop_pwm edge%0d: got %0b expected 0", n_edge, pwm_out);
        end
      end
    end
  endtask

  task automatic test_reversal();
    int exp_lvl;
    chs_mode = 1'b1; chs_power = 4'd10;
    do_reset();
    while (n_edge < 1400) begin
      step();
      if (n_edge == 800) chs_power = 4'd3;
      if (n_edge < 896) exp_lvl = (n_edge / 128 > 10) ? 10 : n_edge / 128;
      else begin
        exp_lvl = 6 - ((n_edge - 896) / 128 + 1);
        if (exp_lvl < 3) exp_lvl = 3;
      end
      checks++;
      if (level !== 4'(exp_lvl) || level > 4'd6) begin
        errors++;
        $display("FAIL reversal_level edge%0d: got %0d expected %0d", n_edge, level, exp_lvl);
      end
    end
    checks++;
    if (state !== S_HOLD || at_target !== 1'b1) begin
      errors++;
      $display("FAIL reversal_hold: state=%0d at=%0b expected 2 1", state, at_target);
    end
  endtask

  task automatic test_extremes();
    int exp_lvl, hi;
    chs_mode2 = 1'b1; chs_power2 = 4'd15;
    @(negedge clk);
    rst2 = 1'b0;
    hi = 0;
    for (int k = 1; k <= 260; k++) begin
      @(posedge clk);
      #1;
      exp_lvl = (k / 16 > 15) ? 15 : k / 16;
      checks++;
      if (level2 !== 4'(exp_lvl)) begin
        errors++;
        $display("FAIL fast_level edge%0d: got %0d expected %0d", k, level2, exp_lvl);
      end
      if (k >= 242 && k <= 257) hi += int'(pwm_out2);
    end
    checks++;
    if (hi != 15) begin
      errors++;
      $display("FAIL fast_duty: got %0d high clk of 16 expected 15", hi);
    end
  endtask

  task automatic test_async_reset();
    chs_mode = 1'b1; chs_power = 4'd10;
    do_reset();
    while (n_edge < 900) step();
    checks++;
    if (level !== 4'd7) begin
      errors++;
      $display("FAIL pre_reset_level: got %0d expected 7", level);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (level !== 4'd0 || pwm_out !== 1'b0 || state !== S_IDLE || at_target !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: level=%0d pwm=%0b state=%0d at=%0b expected 0 0 0 0",
               level, pwm_out, state, at_target);
    end
    @(negedge clk);
    rst = 1'b0;
    n_edge = 0;
    while (n_edge < 128) begin
      step();
      if (n_edge == 127 || n_edge == 128) begin
        checks++;
        if (level !== ((n_edge == 128) ? 4'd1 : 4'd0)) begin
          errors++;
          $display("FAIL restart_level edge%0d: got %0d expected %0d", n_edge, level, (n_edge == 128) ? 1 : 0);
        end
      end
    end
  endtask

  initial begin
    rst2 = 1'b1; chs_mode2 = 1'b0; chs_power2 = 4'd0;
    test_reset();
    test_ramp_up_and_soft_stop();
    test_reversal();
    test_extremes();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chs_power_driver.md
Name: chs_power_driver

Overview:
- Downstream consumer of the mode/power decoder: takes the decoded chs_mode and 4-bit chs_power level and drives the appliance's power stage with a 16-slot PWM waveform.
- Moves the applied level toward the requested level in unit steps at a fixed ramp rate (soft start and soft stop).
- Reports ramp state and an at-target flag to the home controller.

Parameters:
- PRESCALE, 4: clk cycles per PWM slot (>=1; 1 means one slot per clk).
- RAMP_PERIODS, 2: full PWM periods between successive level steps (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- chs_mode  in  1  1 = on (use chs_power); 0 = standby (target 0).
- chs_power  in  4  requested power level, 0..15.
- pwm_out  out  1  power-stage gate, registered.
- level  out  4  currently applied level.
- state  out  2  0=IDLE, 1=UP, 2=HOLD, 3=DOWN.
- at_target  out  1  registered; 1 when level equals target.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. Every register clears immediately on rst=1, including mid-ramp or mid-period.
- Reset values:
  - Outputs: pwm_out=0, level=0, state=IDLE, at_target=0.
  - Internal counters: pre_cnt=0, pwm_cnt=0, rcnt=0.
- target is combinational: chs_mode ? chs_power : 0. Inputs are not sampled; a change takes effect at the next step opportunity.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt==PRESCALE-1).
- Slot counter: pwm_cnt is 4-bit, increments on tick, wraps 15->0. period_end = tick && pwm_cnt==15.
- Ramp counter: rcnt counts period_ends modulo RAMP_PERIODS and is free-running; it is not cleared on target change. step_en = period_end && rcnt==RAMP_PERIODS-1.
- Level update on step_en:
  - level<target: level+1.
  - level>target: level-1.
  - Otherwise unchanged.
  - Exactly one unit per step. No overshoot, no wrap past 0 or 15.
- Level changes only at period boundaries, so the duty cycle never changes mid-period.
- pwm_out <= (level > pwm_cnt), one clk lag.
  - Duty = level/16; level 0 gives constant 0, level 15 gives 15/16.
  - Output is never constantly 1.
- state, registered each clk from current level/target:
  - IDLE if level==0 && target==0.
  - UP if level<target.
  - DOWN if level>target.
  - HOLD if level==target!=0.
- at_target <= (level==target) each clk.
- Boundary cases:
  - Target reversal mid-ramp: direction flips at the next step_en.
  - chs_mode 1->0: ramps down to 0, never an instant cut.
  - Target change coinciding with step_en: the step uses the new target value.
  - target equal to level at step_en: no change.

Test Plan:
- Reset then idle: rst pulse, chs_mode=0, chs_power=9 (defaults) -> level=0, state=IDLE, pwm_out=0 for 1000 clk; at_target=1 from the second clk after rst release.
- Ramp up:
  - Stimulus: chs_mode=1, chs_power=5 from reset release (period=64 clk, step every 128 clk).
  - level=1 after edge 128, level=5 after edge 640.
  - state=UP during the ramp, then HOLD with at_target=1.
  - pwm_out high exactly 20 of each 64 clk.
- Soft stop: from HOLD at level 5, drop chs_mode to 0 -> state=DOWN, level decrements 4,3,2,1,0 at 128-clk spacing, then IDLE with pwm_out=0.
- Reversal: target 10; at level 6 change chs_power to 3 -> next step gives 5, continues to 3, HOLD; level never exceeds 6.
- Extremes, PRESCALE=1 and RAMP_PERIODS=1: chs_power=15 -> level +1 every 16 clk, reaching 15 at edge 240; pwm_out low exactly 1 slot per 16.
- Async reset mid-ramp: assert rst between edges at level 7 -> level, pwm_out, and state clear before the next clk edge; ramp restarts from 0 after release.
